// File: rtl/slice_fcarry_pkg.sv
// Shared definitions for the fracturable carry slice: config field offsets,
// carry-in select encodings and the serial loader state type.
package slice_fcarry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } loader_state_t;

    localparam logic [1:0] CIN_EXT     = 2'b00;
    localparam logic [1:0] CIN_ZERO    = 2'b01;
    localparam logic [1:0] CIN_ONE     = 2'b10;
    localparam logic [1:0] CIN_EXT_ALT = 2'b11;

    function automatic int unsigned tbl_bits(input int unsigned s);
        return 32'd1 << (s + 32'd1);
    endfunction

    function automatic int unsigned lut_cfg_bits(input int unsigned s);
        return tbl_bits(s) + 32'd3;
    endfunction

    function automatic int unsigned mode_off(input int unsigned s);
        return tbl_bits(s);
    endfunction

    function automatic int unsigned reg_en_off(input int unsigned s);
        return tbl_bits(s) + 32'd1;
    endfunction

endpackage

// File: rtl/slice_cfg_loader.sv
// Serial configuration loader: bits shift into a shadow register and are
// copied to the active vector in a single commit cycle.
module slice_cfg_loader
    import slice_fcarry_pkg::*;
#(
    parameter int unsigned CFG_BITS = 143
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic [CFG_BITS-1:0] active
);

    localparam int unsigned CW = $clog2(CFG_BITS);

    loader_state_t       state;
    loader_state_t       state_nx;
    logic [CW-1:0]       cnt;
    logic [CFG_BITS-1:0] shadow;
    logic                accept;
    logic                last;
    logic                commit;

    assign last = (cnt == CW'(CFG_BITS - 1));

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        cfg_done  = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) state_nx = SHIFT;
            end
            SHIFT: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    state_nx = SHIFT;
                end else if (cfg_valid) begin
                    accept = 1'b1;
                    if (last) state_nx = COMMIT;
                end
            end
            COMMIT: begin
                // A restart arriving here drops the pending commit.
                if (cfg_start) begin
                    state_nx = SHIFT;
                end else begin
                    commit   = 1'b1;
                    cfg_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            active <= '0;
        end else begin
            state <= state_nx;
            if (cfg_start) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (accept) shadow <= {cfg_bit, shadow[CFG_BITS-1:1]};
            if (commit) active <= shadow;
        end
    end

endmodule

// File: rtl/slice_fcarry_v2.sv
// Fracturable LUT slice with ripple carry chain, MUX7 pairing and optional
// per-output registers, configured through the serial loader.
module slice_fcarry_v2
    import slice_fcarry_pkg::*;
#(
    parameter int unsigned S_XX_BASE = 4,
    parameter int unsigned NUM_LUTS  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_LUTS*(S_XX_BASE+1)-1:0] luts_in,
    input  logic [NUM_LUTS/2-1:0]             mux7_sel,
    input  logic                              Ci,
    input  logic                              reg_ce,
    input  logic                              cfg_start,
    input  logic                              cfg_valid,
    input  logic                              cfg_bit,
    output logic                              cfg_ready,
    output logic                              cfg_done,
    output logic [NUM_LUTS-1:0]               out_a,
    output logic [NUM_LUTS-1:0]               out_b,
    output logic                              Co
);

    localparam int unsigned T        = tbl_bits(S_XX_BASE);
    localparam int unsigned LUT_CFG  = lut_cfg_bits(S_XX_BASE);
    localparam int unsigned CFG_BITS = NUM_LUTS * LUT_CFG + 3;
    localparam int unsigned MODE_OFF = mode_off(S_XX_BASE);
    localparam int unsigned REG_OFF  = reg_en_off(S_XX_BASE);

    logic [CFG_BITS-1:0] active;
    logic [1:0]          cin_sel;
    logic                mux7_en;

    logic [NUM_LUTS-1:0] o6;
    logic [NUM_LUTS-1:0] p;
    logic [NUM_LUTS-1:0] g;
    logic [NUM_LUTS-1:0] mode;
    logic [NUM_LUTS-1:0] reg_a;
    logic [NUM_LUTS-1:0] reg_b;
    logic [NUM_LUTS:0]   carry;
    logic [NUM_LUTS-1:0] a_comb;
    logic [NUM_LUTS-1:0] b_comb;
    logic [NUM_LUTS-1:0] sync_a;
    logic [NUM_LUTS-1:0] sync_b;

    slice_cfg_loader #(
        .CFG_BITS (CFG_BITS)
    ) u_loader (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .active    (active)
    );

    assign cin_sel = active[CFG_BITS-3 +: 2];
    assign mux7_en = active[CFG_BITS-1];

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic [T-1:0]         tbl;
        logic [S_XX_BASE:0]   addr;
        assign tbl      = active[i*LUT_CFG +: T];
        assign addr     = luts_in[i*(S_XX_BASE+1) +: S_XX_BASE+1];
        assign o6[i]    = tbl[addr];
        assign p[i]     = tbl[{1'b0, addr[S_XX_BASE-1:0]}];
        assign g[i]     = tbl[{1'b1, addr[S_XX_BASE-1:0]}];
        assign mode[i]  = active[i*LUT_CFG + MODE_OFF];
        assign reg_a[i] = active[i*LUT_CFG + REG_OFF];
        assign reg_b[i] = active[i*LUT_CFG + REG_OFF + 1];
    end

    // Whole chain in one process so the ripple is a single combinational cone.
    always_comb begin
        case (cin_sel)
            CIN_ZERO: carry[0] = 1'b0;
            CIN_ONE:  carry[0] = 1'b1;
            default:  carry[0] = Ci;
        endcase
        a_comb = '0;
        for (int unsigned i = 0; i < NUM_LUTS; i++) begin
            a_comb[i]  = mode[i] ? (p[i] ^ carry[i]) : o6[i];
            carry[i+1] = mode[i] ? (p[i] ? carry[i] : g[i]) : carry[i];
        end
    end

    always_comb begin
        b_comb = g;
        if (mux7_en) begin
            for (int unsigned k = 0; k < NUM_LUTS/2; k++) begin
                b_comb[2*k] = mux7_sel[k] ? o6[2*k+1] : o6[2*k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else if (reg_ce) begin
            sync_a <= a_comb;
            sync_b <= b_comb;
        end
    end

    assign out_a = (reg_a & sync_a) | (~reg_a & a_comb);
    assign out_b = (reg_b & sync_b) | (~reg_b & b_comb);
    assign Co    = carry[NUM_LUTS];

endmodule

// File: tb/tb_slice_fcarry_v2.sv
// Randomized bench for slice_fcarry_v2 with a behavioural model of the slice
// and its loader, plus fixed arithmetic cases.
module tb_slice_fcarry_v2;

    localparam int S  = 4;
    localparam int N  = 4;
    localparam int T  = 32;
    localparam int LC = 35;
    localparam int CB = 143;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*(S+1)-1:0]  luts_in;
    logic [N/2-1:0]      mux7_sel;
    logic                Ci;
    logic                reg_ce;
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_bit;
    logic                cfg_ready;
    logic                cfg_done;
    logic [N-1:0]        out_a;
    logic [N-1:0]        out_b;
    logic                Co;

    int checks = 0;
    int errors = 0;

    slice_fcarry_v2 #(
        .S_XX_BASE (S),
        .NUM_LUTS  (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .luts_in   (luts_in),
        .mux7_sel  (mux7_sel),
        .Ci        (Ci),
        .reg_ce    (reg_ce),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .out_a     (out_a),
        .out_b     (out_b),
        .Co        (Co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Combinational behaviour of the slice for a given configuration.
    function automatic void eval(input logic [CB-1:0] cfg, input logic [N*(S+1)-1:0] lin,
                                 input logic [N/2-1:0] m7s, input logic ci,
                                 output logic [N-1:0] a, output logic [N-1:0] b,
                                 output logic co);
        logic [T-1:0] t;
        logic [N-1:0] o6;
        logic         c, pp, gg;
        int           addr, low;
        case (cfg[CB-3 +: 2])
            2'b01:   c = 1'b0;
            2'b10:   c = 1'b1;
            default: c = ci;
        endcase
        a = '0;
        b = '0;
        for (int i = 0; i < N; i++) begin
            t     = cfg[i*LC +: T];
            addr  = int'(lin[i*(S+1) +: S+1]);
            low   = addr % (1 << S);
            o6[i] = t[addr];
            pp    = t[low];
            gg    = t[low + (1 << S)];
            if (cfg[i*LC + T]) begin
                a[i] = pp ^ c;
                c    = pp ? c : gg;
            end else begin
                a[i] = o6[i];
            end
            b[i] = gg;
        end
        if (cfg[CB-1]) begin
            for (int k = 0; k < N/2; k++) b[2*k] = m7s[k] ? o6[2*k+1] : o6[2*k];
        end
        co = c;
    endfunction

    function automatic logic [CB-1:0] make_cfg(input logic [31:0] t0, input logic [31:0] trest,
                                               input logic [N-1:0] modes, input logic [1:0] regen,
                                               input logic [1:0] cin, input logic m7);
        logic [CB-1:0] v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*LC +: T]      = (i == 0) ? t0 : trest;
            v[i*LC + T]       = modes[i];
            v[i*LC + T + 1 +: 2] = regen;
        end
        v[CB-3 +: 2] = cin;
        v[CB-1]      = m7;
        return v;
    endfunction

    function automatic logic [N*(S+1)-1:0] pack(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N*(S+1)-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*(S+1) +: S+1] = {3'b000, b[i], a[i]};
        return v;
    endfunction

    // Model state: committed config, output registers, and load progress.
    logic [CB-1:0] m_cfg    = '0;
    logic [CB-1:0] m_shadow = '0;
    logic [N-1:0]  m_sa = '0, m_sb = '0;
    bit            m_loading = 0, m_pend = 0, m_started = 0;
    int            m_cnt = 0;

    always @(posedge clk) begin
        logic [N-1:0] ea, eb;
        logic         eco;
        eval(m_cfg, luts_in, mux7_sel, Ci, ea, eb, eco);
        if (rst) begin
            m_cfg = '0; m_sa = '0; m_sb = '0;
            m_loading = 0; m_pend = 0; m_cnt = 0;
        end else begin
            if (reg_ce) begin
                m_sa = ea;
                m_sb = eb;
            end
            if (cfg_start) begin
                m_loading = 1; m_cnt = 0; m_pend = 0;
            end else if (m_pend) begin
                m_cfg  = m_shadow;
                m_pend = 0;
            end else if (m_loading && cfg_valid) begin
                m_shadow[m_cnt] = cfg_bit;
                m_cnt++;
                if (m_cnt == CB) begin
                    m_loading = 0;
                    m_pend    = 1;
                end
            end
        end
        m_started = 1;
    end

    always @(negedge clk) begin
        logic [N-1:0] ea, eb, ra, rb;
        logic         eco;
        if (m_started) begin
            eval(m_cfg, luts_in, mux7_sel, Ci, ea, eb, eco);
            for (int i = 0; i < N; i++) begin
                ra[i] = m_cfg[i*LC + T + 1];
                rb[i] = m_cfg[i*LC + T + 2];
            end
            chk("model_out_a", 32'(out_a), 32'((ra & m_sa) | (~ra & ea)));
            chk("model_out_b", 32'(out_b), 32'((rb & m_sb) | (~rb & eb)));
            chk("model_co", 32'(Co), 32'(eco));
            chk("model_cfg_ready", 32'(cfg_ready), 32'(m_loading));
            chk("model_cfg_done", 32'(cfg_done), 32'(m_pend));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        luts_in  = (N*(S+1))'($urandom);
        mux7_sel = (N/2)'($urandom);
        Ci       = 1'($urandom);
        reg_ce   = 1'($urandom);
    endtask

    // Serial load with random stalls; optional restart or reset abort at a bit index.
    task automatic load(input logic [CB-1:0] cfg, input int restart_at, input int abort_at);
        int  idx = 0;
        int  dones = 0;
        bit  restarted = 0;
        rand_inputs();
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        step();
        cfg_start = 1'b0;
        while (idx < CB) begin
            rand_inputs();
            if (idx == abort_at) begin
                rst = 1'b1;
                cfg_valid = 1'b1;
                cfg_bit = cfg[idx];
                step();
                rst = 1'b0;
                cfg_valid = 1'b0;
                return;
            end
            if (idx == restart_at && !restarted) begin
                cfg_start = 1'b1;
                cfg_valid = 1'b1;
                cfg_bit   = 1'($urandom);
                step();
                cfg_start = 1'b0;
                restarted = 1;
                idx = 0;
                continue;
            end
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_bit   = cfg_valid ? cfg[idx] : 1'($urandom);
            step();
            if (cfg_valid) idx++;
        end
        cfg_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cfg_done) dones++;
            step();
        end
        chk("cfg_done_pulses", 32'(dones), 32'd1);
    endtask

    localparam logic [31:0] ADD_TBL = 32'h88886666;

    initial begin
        logic [CB-1:0] pre_abort;
        rst = 1'b1;
        luts_in = (N*(S+1))'($urandom);
        mux7_sel = '0;
        Ci = 1'b1;
        reg_ce = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_bit = 1'b1;
        @(negedge clk);
        chk("rst_out_a", 32'(out_a), 32'd0);
        chk("rst_out_b", 32'(out_b), 32'd0);
        chk("rst_co", 32'(Co), 32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        step();
        rst = 1'b0;
        repeat (6) begin
            luts_in = (N*(S+1))'($urandom);
            cfg_valid = 1'b1;
            cfg_bit = 1'($urandom);
            step();
        end
        cfg_valid = 1'b0;
        Ci = 1'b0;
        @(negedge clk);
        chk("ignored_bits_ready", 32'(cfg_ready), 32'd0);
        chk("ignored_bits_out_a", 32'(out_a), 32'd0);
        chk("ignored_bits_co", 32'(Co), 32'd0);

        load(make_cfg(ADD_TBL, ADD_TBL, 4'hF, 2'b00, 2'b01, 1'b0), -1, -1);
        reg_ce = 1'b0;
        luts_in = pack(4'd11, 4'd6);
        @(negedge clk);
        chk("add_11_6_sum", 32'(out_a), 32'h1);
        chk("add_11_6_co", 32'(Co), 32'd1);
        luts_in = pack(4'd3, 4'd4);
        @(negedge clk);
        chk("add_3_4_sum", 32'(out_a), 32'h7);
        chk("add_3_4_co", 32'(Co), 32'd0);

        load(make_cfg(ADD_TBL, ADD_TBL, 4'hF, 2'b00, 2'b10, 1'b0), -1, -1);
        luts_in = pack(4'd9, 4'b1100);
        @(negedge clk);
        chk("sub_9_3_diff", 32'(out_a), 32'h6);
        chk("sub_9_3_co", 32'(Co), 32'd1);

        load(make_cfg(32'hFFFFFFFF, 32'h0, 4'h0, 2'b00, 2'b00, 1'b1), -1, -1);
        mux7_sel = 2'b00;
        @(negedge clk);
        chk("mux7_sel0_b0", 32'(out_b[0]), 32'd1);
        mux7_sel = 2'b01;
        @(negedge clk);
        chk("mux7_sel1_b0", 32'(out_b[0]), 32'd0);

        load(make_cfg(ADD_TBL, ADD_TBL, 4'hF, 2'b11, 2'b01, 1'b0), -1, -1);
        Ci = 1'b0;
        luts_in = pack(4'd11, 4'd6);
        reg_ce = 1'b1;
        step();
        reg_ce = 1'b0;
        luts_in = pack(4'd3, 4'd4);
        @(negedge clk);
        chk("reg_first_sum", 32'(out_a), 32'h1);
        chk("reg_first_g", 32'(out_b), 32'h2);
        step();
        @(negedge clk);
        chk("reg_hold_sum", 32'(out_a), 32'h1);
        reg_ce = 1'b1;
        step();
        reg_ce = 1'b0;
        @(negedge clk);
        chk("reg_new_sum", 32'(out_a), 32'h7);

        repeat (3) begin
            load({$urandom, $urandom, $urandom, $urandom, $urandom}, -1, -1);
            repeat (20) begin
                rand_inputs();
                step();
            end
        end
        load({$urandom, $urandom, $urandom, $urandom, $urandom}, 50, -1);
        repeat (20) begin
            rand_inputs();
            step();
        end

        pre_abort = make_cfg(32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0, 2'b00, 2'b10, 1'b0);
        load(pre_abort, -1, 100);
        repeat (5) begin
            rand_inputs();
            step();
        end
        luts_in = pack(4'd5, 4'd10);
        Ci = 1'b1;
        @(negedge clk);
        chk("abort_out_a", 32'(out_a), 32'd0);
        chk("abort_out_b", 32'(out_b), 32'd0);
        chk("abort_co", 32'(Co), 32'd1);
        chk("abort_cfg_ready", 32'(cfg_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
